// File: rtl/data_ram.sv
// Byte-addressable DEPTH x 32 data memory on a shared tristate bus.
// A clear sequencer zeroes every word after reset before any access is honoured.
module data_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_addr_in,
  input  logic        ram_re_in,
  input  logic        ram_we_in,
  input  logic [1:0]  ram_width_in,
  inout  wire  [31:0] ram_data,
  output logic        busy_out,
  output logic        misalign_out,
  output logic        range_err_out
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_cnt;
  logic [AW-1:0]   w_clr_cnt_nxt;
  logic            w_clr_we;
  logic            r_misalign;
  logic            r_range_err;

  logic [31:0]     r_mem [DEPTH];

  logic [AW-1:0]   w_idx;
  logic [1:0]      w_lane;
  logic            w_oor;
  logic            w_mis;
  logic            w_valid;
  logic            w_idle;
  logic            w_access;
  logic            w_rd_drive;
  logic            w_wr_en;
  logic [31:0]     w_rword;
  logic [31:0]     w_rd_data;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [AW-1:0]   w_waddr;

  // Address decode: word index, byte lane, range and alignment
  assign w_idx    = ram_addr_in[AW+1:2];
  assign w_lane   = ram_addr_in[1:0];
  assign w_oor    = |ram_addr_in[31:AW+2];
  assign w_idle   = (r_state == ST_IDLE);
  assign w_access = ram_re_in | ram_we_in;

  always_comb begin
    w_mis = 1'b0;
    case (ram_width_in)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = w_lane[0];
      2'b10:   w_mis = (w_lane != 2'b00);
      default: w_mis = 1'b1;
    endcase
  end

  assign w_valid = ~w_mis & ~w_oor;

  // A simultaneous read and write is a write; the read path stays off.
  assign w_rd_drive = w_idle & ram_re_in & ~ram_we_in;
  assign w_wr_en    = w_idle & ram_we_in & w_valid & ~rst;

  // Next-state logic for the clear sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we      = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (&r_clr_cnt) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CLEAR;
      r_clr_cnt   <= '0;
      r_misalign  <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_misalign  <= w_idle & w_access & w_mis;
      r_range_err <= w_idle & w_access & w_oor & ~w_mis;
    end
  end

  // Single write port shared by the clear sequencer and stores
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = ram_data;
    w_waddr = w_idx;
    if (w_clr_we) begin
      w_be    = 4'b1111;
      w_wdata = 32'h0;
      w_waddr = r_clr_cnt;
    end else if (w_wr_en) begin
      case (ram_width_in)
        2'b00: begin
          w_be    = 4'b0001 << w_lane;
          w_wdata = {4{ram_data[7:0]}};
        end
        2'b01: begin
          w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{ram_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = ram_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) begin
        r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Load data is right-justified and zero-extended; invalid loads return 0.
  assign w_rword = r_mem[w_idx];

  always_comb begin
    w_rd_data = 32'h0;
    if (w_valid) begin
      case (ram_width_in)
        2'b00:   w_rd_data = (w_rword >> {w_lane, 3'b000}) & 32'h0000_00FF;
        2'b01:   w_rd_data = {16'h0, (w_lane[1] ? w_rword[31:16] : w_rword[15:0])};
        default: w_rd_data = w_rword;
      endcase
    end
  end

  assign ram_data = w_rd_drive ? w_rd_data : 32'bz;

  assign busy_out      = (r_state == ST_CLEAR);
  assign misalign_out  = r_misalign;
  assign range_err_out = r_range_err;

endmodule

// File: tb/tb_data_ram.sv
// Randomized bench for data_ram against a byte-array reference model,
// with a per-cycle expected queue drained by an independent monitor.
module tb_data_ram;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NB    = DEPTH * 4;
  localparam int EW    = 36;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        re;
  logic        we;
  logic [1:0]  width;
  logic [31:0] addr;
  logic [31:0] tb_drv;
  logic        tb_oe;
  wire  [31:0] ram_data;
  logic        busy;
  logic        mis;
  logic        rng;

  assign ram_data = tb_oe ? tb_drv : 32'bz;

  data_ram #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ram_addr_in   (addr),
    .ram_re_in     (re),
    .ram_we_in     (we),
    .ram_width_in  (width),
    .ram_data      (ram_data),
    .busy_out      (busy),
    .misalign_out  (mis),
    .range_err_out (rng)
  );

  // Scoreboard: {known, busy, misalign, range_err, bus}
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: a plain byte array plus clear-countdown
  logic [7:0] mb [NB];
  int         clr_left;
  bit         m_mis;
  bit         m_rng;
  bit         known;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t addr=%h: got %h expected %h", name, $time, addr, act, exp);
    end
  endtask

  // Monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[35]) begin
          chk1("busy", busy, e[34]);
          chk1("misalign", mis, e[33]);
          chk1("range_err", rng, e[32]);
          chk32("bus", ram_data, e[31:0]);
        end
      end
    end
  end

  // Driver: one call = one clock cycle of stimulus
  task automatic cyc(input bit r, input bit rd, input bit wr, input logic [1:0] w,
                     input logic [31:0] a, input logic [31:0] d);
    bit          busy_m;
    bit          mis_a;
    bit          oor_a;
    bit          ok;
    logic [31:0] eb;
    int          n;
    @(posedge clk);
    #1;
    rst = r; re = rd; we = wr; width = w; addr = a;
    busy_m = (clr_left > 0);
    n      = 1 << w;
    mis_a  = (w == 2'd3) || ((a % n) != 0);
    oor_a  = (a >= NB);
    ok     = !mis_a && !oor_a;
    if (!busy_m && rd && !wr) begin
      tb_oe = 1'b0;
      eb    = 32'h0;
      if (ok) for (int k = 0; k < n; k++) eb[8*k +: 8] = mb[a + k];
    end else begin
      tb_oe  = 1'b1;
      tb_drv = d;
      eb     = d;
    end
    exp_q.push_back({known, busy_m, m_mis, m_rng, eb});
    // Model effect of the upcoming edge
    if (r) begin
      clr_left = DEPTH;
      m_mis    = 1'b0;
      m_rng    = 1'b0;
      known    = 1'b1;
    end else if (busy_m) begin
      clr_left--;
      m_mis = 1'b0;
      m_rng = 1'b0;
      if (clr_left == 0) for (int i = 0; i < NB; i++) mb[i] = 8'h00;
    end else begin
      m_mis = (rd || wr) && mis_a;
      m_rng = (rd || wr) && oor_a && !mis_a;
      if (wr && ok) for (int k = 0; k < n; k++) mb[a + k] = d[8*k +: 8];
    end
  endtask

  task automatic rnd_cyc();
    logic [31:0] a;
    logic [1:0]  w;
    bit          rd;
    bit          wr;
    if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h0001_0000;
    else a = 32'($urandom_range(0, NB - 1));
    w  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    rd = ($urandom_range(0, 1) == 1);
    wr = ($urandom_range(0, 2) == 0);
    if (w == 2'd1 && $urandom_range(0, 1) == 1) a[0] = 1'b0;
    if (w == 2'd2 && $urandom_range(0, 1) == 1) a[1:0] = 2'b00;
    cyc(1'b0, rd, wr, w, a, $urandom());
  endtask

  initial begin
    int guard;
    rst = 1'b1; re = 1'b0; we = 1'b0; width = 2'd0; addr = 32'h0;
    tb_oe = 1'b1; tb_drv = 32'h0;
    known = 1'b0; clr_left = 0; m_mis = 1'b0; m_rng = 1'b0;
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;

    // Reset sweep with ignored traffic while busy
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) rnd_cyc();
    cyc(1'b0, 1'b1, 1'b0, 2'd2, 32'h3C, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, $urandom());

    // Lane writes
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 32'h8, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 1'b1, 2'd0, 32'hA, 32'h0000_0011);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 32'h8, 32'h0000_2233);
    cyc(1'b0, 1'b1, 1'b0, 2'd2, 32'h8, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 2'd0, 32'hB, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 2'd1, 32'hA, 32'h0);

    // Misalign and range faults
    cyc(1'b0, 1'b0, 1'b1, 2'd2, 32'h4, 32'h5566_7788);
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 32'h5, 32'hAAAA_BBBB);
    cyc(1'b0, 1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 2'd2, 32'h0001_0000, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h1234_5678);
    cyc(1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0F0F_0F0F);

    // Simultaneous strobes, then idle bus
    cyc(1'b0, 1'b1, 1'b1, 2'd2, 32'h4, 32'hCAFEF00D);
    cyc(1'b0, 1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom(), $urandom());

    // Random traffic
    for (int i = 0; i < 300; i++) rnd_cyc();

    // Reset mid-clear at clear cycle 7, with ignored traffic throughout
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) rnd_cyc();
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) rnd_cyc();
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, 2'd2, 32'(4 * i), 32'h0);

    for (int i = 0; i < 200; i++) rnd_cyc();
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
